j1_core_p: RTL and testbench

J1_CORE_P -- requirements
Module: j1_core_p

---
 rtl/j1_pkg.sv | 49 ++++
 rtl/j1_stack.sv | 40 ++++
 rtl/j1_core_p.sv | 218 +++++++++++++++++++++
 tb/tb_j1_core_p.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/j1_pkg.sv
// Shared definitions for the J1 stack processor: ALU opcodes, ALU side-effect
// functions and the instruction-class encodings found in insn[15:13].
package j1_pkg;

  typedef enum logic [4:0] {
    OP_T     = 5'd0,
    OP_N     = 5'd1,
    OP_ADD   = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_XOR   = 5'd5,
    OP_INV   = 5'd6,
    OP_EQ    = 5'd7,
    OP_LT    = 5'd8,
    OP_ASR1  = 5'd9,
    OP_SHL1  = 5'd10,
    OP_R     = 5'd11,
    OP_SUB   = 5'd12,
    OP_IODIN = 5'd13,
    OP_DEPTH = 5'd14,
    OP_ULT   = 5'd15,
    OP_DIN   = 5'd16,
    OP_BYTE  = 5'd17,
    OP_SHR   = 5'd18,
    OP_SHL   = 5'd19,
    OP_BREV  = 5'd20,
    OP_MULL  = 5'd21,
    OP_MULH  = 5'd22,
    OP_EINT  = 5'd23,
    OP_DINT  = 5'd24
  } alu_op_e;

  typedef enum logic [2:0] {
    FN_NONE = 3'd0,
    FN_T2N  = 3'd1,
    FN_T2R  = 3'd2,
    FN_WR16 = 3'd3,
    FN_IOW  = 3'd4,
    FN_IOR  = 3'd5,
    FN_WR8  = 3'd6
  } func_e;

  // Classes with insn[15]=0; insn[15]=1 is always a literal push.
  localparam logic [2:0] CLS_JMP  = 3'b000;
  localparam logic [2:0] CLS_CJMP = 3'b001;
  localparam logic [2:0] CLS_CALL = 3'b010;
  localparam logic [2:0] CLS_ALU  = 3'b011;

endpackage

// File: rtl/j1_stack.sv
// Circular register-file stack used for both the data and return stacks.
// rd is the entry under the pointer; writes land at the post-move pointer.
module j1_stack
  import j1_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [WIDTH-1:0]         wd,
  input  logic [1:0]               delta,
  output logic [WIDTH-1:0]         rd,
  output logic [$clog2(DEPTH)-1:0] sp,
  output logic                     wrap
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic signed [AW+1:0] sum;
  logic [AW-1:0]     sp_n;

  // Two guard bits: bit AW+1 flags a move below zero, bit AW a move past DEPTH-1.
  assign sum  = $signed({2'b00, sp}) + $signed({{AW{delta[1]}}, delta});
  assign sp_n = sum[AW-1:0];
  assign wrap = sum[AW+1] | sum[AW];
  assign rd   = mem[sp];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sp <= '0;
    else       sp <= sp_n;
  end

  always_ff @(posedge clk) begin
    if (we) mem[sp_n] <= wd;
  end

endmodule

// File: rtl/j1_core_p.sv
// J1 stack CPU core: one instruction per clock, T held in a register, N and R
// read from j1_stack instances. Optional interrupts via `define J1_INTERRUPT_EN.
module j1_core_p
  import j1_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DDEPTH  = 32,
  parameter int RDEPTH  = 32,
  parameter int CODE_AW = 13,
  parameter int IRQ_VEC = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        insn,
  output logic [CODE_AW-1:0] code_addr,
  output logic [15:0]        mem_addr,
  output logic [15:0]        mem_raddr,
  output logic [WIDTH-1:0]   dout,
  input  logic [WIDTH-1:0]   din,
  input  logic [WIDTH-1:0]   io_din,
  output logic               mem_wr16,
  output logic               mem_wr8,
  output logic               io_wr,
  output logic               io_rd,
  input  logic               irq,
  output logic               irq_ack,
  output logic               fault
);

  localparam int DAW = $clog2(DDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam int SHW = $clog2(WIDTH);

  logic [CODE_AW-1:0] pc, pc_n, pc_inc, target;
  logic [WIDTH-1:0]   t, t_n, n, r, alu_out, brev;
  logic [2*WIDTH-1:0] prod;
  logic               reboot, take_irq, exec, is_alu, ret;
  logic [2:0]         cls;
  alu_op_e            op;
  func_e              func;
  logic [DAW-1:0]     dsp;
  logic [RAW-1:0]     unused_rsp;
  logic               d_we, r_we, d_wrap, r_wrap;
  logic [1:0]         d_delta, r_delta;
  logic [WIDTH-1:0]   d_wd, r_wd;

  assign cls    = insn[15:13];
  assign op     = alu_op_e'(insn[12:8]);
  assign func   = func_e'(insn[6:4]);
  assign ret    = insn[7];
  assign is_alu = (cls == CLS_ALU);
  assign target = CODE_AW'(insn[12:0]);
  assign pc_inc = pc + 1'b1;

`ifdef J1_INTERRUPT_EN
  logic ie;

  assign take_irq = irq & ie & ~reboot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             ie <= 1'b0;
    else if (take_irq)                     ie <= 1'b0;
    else if (exec && is_alu && op == OP_EINT) ie <= 1'b1;
    else if (exec && is_alu && op == OP_DINT) ie <= 1'b0;
  end
`else
  logic unused_irq;

  assign unused_irq = irq;
  assign take_irq   = 1'b0;
`endif

  // An accepted interrupt replaces the fetched instruction, which is not executed.
  assign exec    = ~reboot & ~take_irq;
  assign irq_ack = take_irq;

  assign prod = {{WIDTH{1'b0}}, n} * {{WIDTH{1'b0}}, t};

  always_comb begin
    brev = '0;
    for (int i = 0; i < WIDTH; i++) brev[i] = t[WIDTH-1-i];
  end

  always_comb begin
    alu_out = t;
    case (op)
      OP_T:     alu_out = t;
      OP_N:     alu_out = n;
      OP_ADD:   alu_out = t + n;
      OP_AND:   alu_out = t & n;
      OP_OR:    alu_out = t | n;
      OP_XOR:   alu_out = t ^ n;
      OP_INV:   alu_out = ~t;
      OP_EQ:    alu_out = {WIDTH{n == t}};
      OP_LT:    alu_out = {WIDTH{$signed(n) < $signed(t)}};
      OP_ASR1:  alu_out = {t[WIDTH-1], t[WIDTH-1:1]};
      OP_SHL1:  alu_out = {t[WIDTH-2:0], 1'b0};
      OP_R:     alu_out = r;
      OP_SUB:   alu_out = n - t;
      OP_IODIN: alu_out = io_din;
      OP_DEPTH: alu_out = WIDTH'(dsp);
      OP_ULT:   alu_out = {WIDTH{n < t}};
      OP_DIN:   alu_out = din;
      OP_BYTE:  alu_out = WIDTH'(t[0] ? din[15:8] : din[7:0]);
      OP_SHR:   alu_out = n >> t[SHW-1:0];
      OP_SHL:   alu_out = n << t[SHW-1:0];
      OP_BREV:  alu_out = brev;
      OP_MULL:  alu_out = prod[WIDTH-1:0];
      OP_MULH:  alu_out = prod[2*WIDTH-1:WIDTH];
      default:  alu_out = t;
    endcase
  end

  always_comb begin
    pc_n = pc_inc;
    if (reboot)        pc_n = '0;
    else if (take_irq) pc_n = CODE_AW'(IRQ_VEC);
    else if (insn[15]) pc_n = pc_inc;
    else begin
      case (cls)
        CLS_JMP, CLS_CALL: pc_n = target;
        CLS_CJMP:          pc_n = (t == '0) ? target : pc_inc;
        default:           if (ret) pc_n = r[CODE_AW:1];
      endcase
    end
  end

  always_comb begin
    t_n = t;
    if (exec) begin
      if (insn[15])              t_n = WIDTH'(insn[14:0]);
      else if (cls == CLS_CJMP)  t_n = n;
      else if (is_alu)           t_n = alu_out;
    end
  end

  // Return addresses are stored as byte addresses, hence the extra zero LSB.
  always_comb begin
    d_we    = 1'b0;
    d_delta = 2'b00;
    d_wd    = t;
    r_we    = 1'b0;
    r_delta = 2'b00;
    r_wd    = t;
    if (take_irq) begin
      r_we    = 1'b1;
      r_delta = 2'b01;
      r_wd    = WIDTH'({pc, 1'b0});
    end else if (exec) begin
      if (insn[15]) begin
        d_we    = 1'b1;
        d_delta = 2'b01;
      end else begin
        case (cls)
          CLS_CJMP: d_delta = 2'b11;
          CLS_CALL: begin
            r_we    = 1'b1;
            r_delta = 2'b01;
            r_wd    = WIDTH'({pc_inc, 1'b0});
          end
          CLS_ALU: begin
            d_we    = (func == FN_T2N);
            d_delta = insn[1:0];
            r_we    = (func == FN_T2R);
            r_delta = insn[3:2];
          end
          default: ;
        endcase
      end
    end
  end

  j1_stack #(.WIDTH(WIDTH), .DEPTH(DDEPTH)) u_dstack (
    .clk   (clk),
    .reset (reset),
    .we    (d_we),
    .wd    (d_wd),
    .delta (d_delta),
    .rd    (n),
    .sp    (dsp),
    .wrap  (d_wrap)
  );

  j1_stack #(.WIDTH(WIDTH), .DEPTH(RDEPTH)) u_rstack (
    .clk   (clk),
    .reset (reset),
    .we    (r_we),
    .wd    (r_wd),
    .delta (r_delta),
    .rd    (r),
    .sp    (unused_rsp),
    .wrap  (r_wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= '0;
      t      <= '0;
      reboot <= 1'b1;
      fault  <= 1'b0;
    end else begin
      pc     <= pc_n;
      t      <= t_n;
      reboot <= 1'b0;
      fault  <= fault | d_wrap | r_wrap;
    end
  end

  assign code_addr = pc_n;
  assign mem_addr  = t[15:0];
  assign mem_raddr = t_n[15:0];
  assign dout      = n;
  assign mem_wr16  = exec & is_alu & (func == FN_WR16);
  assign mem_wr8   = exec & is_alu & (func == FN_WR8);
  assign io_wr     = exec & is_alu & (func == FN_IOW);
  assign io_rd     = exec & is_alu & (func == FN_IOR);

endmodule

// File: tb/tb_j1_core_p.sv
// Directed bench for j1_core_p built at WIDTH=32; interrupt checks follow J1_INTERRUPT_EN.
module tb_j1_core_p;

  localparam logic [4:0] A_T = 5'd0, A_N = 5'd1, A_ADD = 5'd2, A_INV = 5'd6, A_LT = 5'd8;
  localparam logic [4:0] A_R = 5'd11, A_DEPTH = 5'd14, A_ULT = 5'd15, A_BYTE = 5'd17;
  localparam logic [4:0] A_SHL = 5'd19, A_MULL = 5'd21, A_MULH = 5'd22, A_EINT = 5'd23;
  localparam logic [4:0] A_UNDEF = 5'd27;
  localparam logic [2:0] F_NONE = 3'd0, F_T2N = 3'd1, F_WR16 = 3'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] insn;
  logic [12:0] code_addr;
  logic [15:0] mem_addr, mem_raddr;
  logic [31:0] dout, din, io_din;
  logic        mem_wr16, mem_wr8, io_wr, io_rd, irq, irq_ack, fault;
  int          checks = 0;
  int          errors = 0;

  j1_core_p #(.WIDTH(32), .DDEPTH(32), .RDEPTH(32), .CODE_AW(13), .IRQ_VEC(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .insn      (insn),
    .code_addr (code_addr),
    .mem_addr  (mem_addr),
    .mem_raddr (mem_raddr),
    .dout      (dout),
    .din       (din),
    .io_din    (io_din),
    .mem_wr16  (mem_wr16),
    .mem_wr8   (mem_wr8),
    .io_wr     (io_wr),
    .io_rd     (io_rd),
    .irq       (irq),
    .irq_ack   (irq_ack),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu(input logic [4:0] o, input logic rt, input logic [2:0] f,
                                      input logic [1:0] rd, input logic [1:0] dd);
    return {3'b011, o, rt, f, rd, dd};
  endfunction

  function automatic logic [15:0] lit(input logic [14:0] v);
    return {1'b1, v};
  endfunction

  function automatic logic [15:0] br(input logic [2:0] c, input logic [12:0] a);
    return {c, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; combinational checks follow 1 unit later.
  task automatic set_insn(input logic [15:0] i);
    insn = i;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [15:0] i);
    set_insn(i);
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    insn   = 16'h0000;
    irq    = 1'b0;
    din    = 32'h0000_BEEF;
    io_din = 32'h0;
    tick();
    check("reset_code_addr", code_addr, 0);
    check("reset_T", mem_addr, 0);
    check("reset_fault", fault, 0);
    check("reset_irq_ack", irq_ack, 0);
    tick();
    reset = 1'b0;

    // Reboot cycle: a store in the instruction slot must not strobe.
    set_insn(alu(A_T, 0, F_WR16, 2'b00, 2'b00));
    check("reboot_code_addr", code_addr, 0);
    check("reboot_wr16", mem_wr16, 0);
    tick();

    set_insn(lit(15'h1234));
    check("seq_code_addr", code_addr, 1);
    tick();
    exec(lit(15'h0011));
    exec(alu(A_ADD, 0, F_NONE, 2'b00, 2'b11));
    check("add_T", mem_addr, 16'h1245);
    check("add_N", dout, 0);
    exec(alu(A_DEPTH, 0, F_T2N, 2'b00, 2'b01));
    check("depth_T", mem_addr, 1);
    check("depth_N", dout, 32'h1245);

    exec(lit(15'd3));
    exec(lit(15'd5));
    exec(alu(A_MULL, 0, F_NONE, 2'b00, 2'b11));
    check("mull_T", mem_addr, 15);
    check("mull_N", dout, 1);
    exec(lit(15'd1));
    set_insn(lit(15'd31));
    check("raddr_lit", mem_raddr, 16'h001f);
    tick();
    set_insn(alu(A_SHL, 0, F_NONE, 2'b00, 2'b11));
    check("raddr_shl", mem_raddr, 0);
    tick();
    exec(lit(15'd0));
    check("shl_result", dout, 32'h8000_0000);
    exec(alu(A_INV, 0, F_NONE, 2'b00, 2'b00));
    exec(alu(A_MULH, 0, F_NONE, 2'b00, 2'b11));
    check("mulh_T_low", mem_addr, 16'hffff);
    exec(lit(15'd0));
    check("mulh_result", dout, 32'h7fff_ffff);

    exec(lit(15'd5));
    exec(lit(15'd15));
    exec(alu(A_INV, 0, F_NONE, 2'b00, 2'b00));
    exec(alu(A_ULT, 0, F_NONE, 2'b00, 2'b00));
    check("ult_true", mem_addr, 16'hffff);
    exec(alu(A_LT, 0, F_NONE, 2'b00, 2'b00));
    check("lt_false", mem_addr, 0);

    exec(lit(15'd1));
    exec(alu(A_BYTE, 0, F_NONE, 2'b00, 2'b00));
    check("byte_hi", mem_addr, 16'h00be);
    set_insn(alu(A_T, 0, F_WR16, 2'b00, 2'b00));
    check("wr16_strobe", mem_wr16, 1);
    check("wr8_quiet", mem_wr8, 0);
    check("iow_quiet", io_wr, 0);
    check("ior_quiet", io_rd, 0);
    tick();
    exec(alu(A_UNDEF, 0, F_NONE, 2'b00, 2'b00));
    check("undef_op_T", mem_addr, 16'h00be);

    exec(lit(15'd0));
    set_insn(br(3'b001, 13'h100));
    check("cjump_taken", code_addr, 13'h100);
    tick();
    exec(alu(A_DEPTH, 0, F_T2N, 2'b00, 2'b01));
    check("cjump_depth", mem_addr, 8);
    check("cjump_popped_T", dout, 32'h00be);
    exec(lit(15'd7));
    set_insn(br(3'b001, 13'h200));
    check("cjump_not_taken", code_addr, 13'h103);
    tick();
    set_insn(br(3'b010, 13'h300));
    check("call_target", code_addr, 13'h300);
    tick();
    exec(alu(A_R, 0, F_T2N, 2'b00, 2'b01));
    check("call_ret_addr", mem_addr, 16'h0208);
    set_insn(alu(A_T, 1, F_NONE, 2'b11, 2'b00));
    check("return_target", code_addr, 13'h104);
    tick();
    exec(alu(A_EINT, 0, F_NONE, 2'b00, 2'b00));
    set_insn(br(3'b000, 13'h040));
    check("jump_target", code_addr, 13'h040);
    tick();

`ifdef J1_INTERRUPT_EN
    irq = 1'b1;
    set_insn(lit(15'h555));
    check("irq_ack_pulse", irq_ack, 1);
    check("irq_vector", code_addr, 1);
    tick();
    irq = 1'b0;
    check("irq_T_kept", mem_addr, 16'h0208);
    check("irq_ack_done", irq_ack, 0);
    exec(alu(A_R, 0, F_T2N, 2'b00, 2'b01));
    check("irq_R_top", mem_addr, 16'h0080);
    set_insn(alu(A_T, 1, F_NONE, 2'b11, 2'b00));
    check("irq_resume", code_addr, 13'h040);
    tick();
    irq = 1'b1;
    set_insn(lit(15'h555));
    check("irq_held_off_ack", irq_ack, 0);
    check("irq_held_off_pc", code_addr, 13'h041);
    tick();
    irq = 1'b0;
    check("irq_held_off_exec", mem_addr, 16'h0555);
`else
    irq = 1'b1;
    set_insn(lit(15'h555));
    check("irq_ignored_ack", irq_ack, 0);
    check("irq_ignored_pc", code_addr, 13'h041);
    tick();
    irq = 1'b0;
    check("irq_ignored_exec", mem_addr, 16'h0555);
`endif
    check("no_fault_yet", fault, 0);

    // Reset arriving while a store is on the bus kills the strobe immediately.
    set_insn(alu(A_T, 0, F_WR16, 2'b00, 2'b00));
    check("wr16_before_reset", mem_wr16, 1);
    reset = 1'b1;
    #1;
    check("wr16_in_reset", mem_wr16, 0);
    check("code_addr_in_reset", code_addr, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("wr16_reboot", mem_wr16, 0);
    check("code_addr_reboot", code_addr, 0);
    tick();

    for (int i = 0; i < 31; i++) exec(lit(15'(i)));
    check("fault_31_pushes", fault, 0);
    exec(lit(15'd31));
    exec(lit(15'd32));
    check("fault_33_pushes", fault, 1);
    for (int i = 0; i < 3; i++) exec(alu(A_N, 0, F_NONE, 2'b00, 2'b11));
    check("fault_sticky", fault, 1);

    reset = 1'b1;
    #1;
    check("fault_cleared", fault, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    set_insn(alu(A_N, 0, F_NONE, 2'b00, 2'b11));
    check("underflow_pre", fault, 0);
    tick();
    check("underflow_fault", fault, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
